coupe_mem_mapper: RTL

//  Parametrised memory-paging and contention unit for the SAM Coupe core: owns LMPR/HMPR and

---
 rtl/coupe_mem_mapper.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/coupe_mem_mapper.sv
// rtl/coupe_mem_mapper.sv - SAM Coupe paging, address translation and contention hold
module coupe_mem_mapper #(
    parameter int             PAGE_BITS = 5,
    parameter int             EXT_BITS  = 8,
    parameter int             EXT_PAGES = 256,
    parameter logic [8:0]     EXT_BASE  = 9'h40,
    parameter logic [4:0]     ROM_BASE  = 5'h10,
    parameter int             ADDR_W    = 25,
    parameter int             CONTEND   = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [15:0]       addr,
    input  logic [7:0]        din,
    input  logic              nMREQ,
    input  logic              nIORQ,
    input  logic              nRD,
    input  logic              nWR,
    input  logic              nM1,
    input  logic              nRFSH,
    input  logic              mem_cont,
    input  logic              io_cont,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              rom_sel,
    output logic [7:0]        port_dout,
    output logic              port_sel,
    output logic [7:0]        border,
    output logic              cpu_hold
);

    // Ext page registers keep only as many bits as there are fitted pages.
    localparam logic [EXT_BITS-1:0] EXT_MASK =
        (EXT_PAGES == 0 || EXT_PAGES >= (1 << EXT_BITS)) ? {EXT_BITS{1'b1}}
                                                          : EXT_BITS'(EXT_PAGES - 1);
    localparam bit EXT_EN  = (EXT_PAGES != 0);
    localparam bit CONT_EN = (CONTEND != 0);
    localparam int EXT_AW  = ADDR_W - 14;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } cont_state_t;

    logic [7:0]          lmpr;
    logic [7:0]          hmpr;
    logic [EXT_BITS-1:0] ext_c;
    logic [EXT_BITS-1:0] ext_d;
    logic                port_we;
    logic                old_we;
    logic                port_wr_stb;

    logic                rom0;
    logic                rom1;
    logic                ext_hit;
    logic                wp;
    logic [PAGE_BITS-1:0] int_page;
    logic [8:0]          ext_page;

    logic                ram_acc;
    logic                io_acc;
    logic                ram_acc_q;
    logic                io_acc_q;
    logic                mem_cont_q;
    logic                io_cont_q;
    cont_state_t         ram_state;
    cont_state_t         ram_next;
    cont_state_t         io_state;
    cont_state_t         io_next;

    // A port write fires once, on the first clock of an I/O write cycle.
    assign port_we     = ~nIORQ & ~nWR & nM1;
    assign port_wr_stb = port_we & ~old_we;

    // Mapper register file and write-edge tracker.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lmpr   <= 8'h00;
            hmpr   <= 8'h00;
            ext_c  <= '0;
            ext_d  <= '0;
            border <= 8'h80;
            old_we <= 1'b0;
        end else begin
            old_we <= port_we;
            if (port_wr_stb) begin
                case (addr[7:0])
                    8'd250:  lmpr   <= din;
                    8'd251:  hmpr   <= din;
                    8'd254:  border <= din;
                    8'd128:  ext_c  <= EXT_BITS'(din) & EXT_MASK;
                    8'd129:  ext_d  <= EXT_BITS'(din) & EXT_MASK;
                    default: ;
                endcase
            end
        end
    end

    // Region decode: ROM overrides external RAM, which overrides internal RAM.
    assign rom0     = ~lmpr[5] & (addr[15:14] == 2'd0);
    assign rom1     = lmpr[6] & (addr[15:14] == 2'd3);
    assign rom_sel  = rom0 | rom1;
    assign ext_hit  = EXT_EN & hmpr[7] & addr[15];
    assign wp       = lmpr[7] & (addr[15:14] == 2'd0);
    assign int_page = (addr[15] ? hmpr[PAGE_BITS-1:0] : lmpr[PAGE_BITS-1:0])
                      + PAGE_BITS'(addr[14]);
    assign ext_page = EXT_BASE + 9'(addr[14] ? ext_d : ext_c);

    // Flat address translation.
    always_comb begin
        ram_addr = '0;
        if (rom_sel) begin
            ram_addr = ADDR_W'({ROM_BASE, addr[15], addr[13:0]});
        end else if (ext_hit) begin
            ram_addr = ADDR_W'({EXT_AW'(ext_page), addr[13:0]});
        end else begin
            ram_addr = ADDR_W'({int_page, addr[13:0]});
        end
    end

    assign ram_we = ~nMREQ & ~nWR & ~rom_sel & ~wp;

    // Readback of the paging registers; idle bus reads as all ones.
    always_comb begin
        port_sel  = 1'b0;
        port_dout = 8'hFF;
        if (~nIORQ & ~nRD & nM1) begin
            case (addr[7:0])
                8'd250: begin port_sel = 1'b1; port_dout = lmpr;      end
                8'd251: begin port_sel = 1'b1; port_dout = hmpr;      end
                8'd128: begin port_sel = 1'b1; port_dout = 8'(ext_c); end
                8'd129: begin port_sel = 1'b1; port_dout = 8'(ext_d); end
                default: ;
            endcase
        end
    end

    // ROM and external RAM are never slowed by the video fetch.
    assign ram_acc = ~nMREQ & nRFSH & ~rom_sel & ~ext_hit;
    assign io_acc  = ~nIORQ & ~(nRD & nWR) & nM1 & (&addr[7:3]);

    // Contention next-state: wait starts on a new access while contended, ends when contention drops.
    always_comb begin
        ram_next = ram_state;
        io_next  = io_state;
        case (ram_state)
            IDLE: if (CONT_EN && ram_acc && !ram_acc_q && mem_cont) ram_next = WAIT;
            WAIT: if (!mem_cont && mem_cont_q) ram_next = IDLE;
            default: ram_next = IDLE;
        endcase
        case (io_state)
            IDLE: if (CONT_EN && io_acc && !io_acc_q && io_cont) io_next = WAIT;
            WAIT: if (!io_cont && io_cont_q) io_next = IDLE;
            default: io_next = IDLE;
        endcase
    end

    // Contention state, edge-detect history and registered hold output.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ram_state  <= IDLE;
            io_state   <= IDLE;
            ram_acc_q  <= 1'b0;
            io_acc_q   <= 1'b0;
            mem_cont_q <= 1'b0;
            io_cont_q  <= 1'b0;
            cpu_hold   <= 1'b0;
        end else begin
            ram_state  <= ram_next;
            io_state   <= io_next;
            ram_acc_q  <= ram_acc;
            io_acc_q   <= io_acc;
            mem_cont_q <= mem_cont;
            io_cont_q  <= io_cont;
            cpu_hold   <= (ram_next == WAIT) | (io_next == WAIT);
        end
    end

endmodule
